// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic valid/ready pipeline register between core stages.
// Carries a control vector and a payload, with an optional 2-entry skid buffer.
//
// Ports:
//   clk, reset      stage clock (rising edge), async active-high reset
//   flush           synchronous kill of every held entry
//   in_valid/in_ready/in_ctrl/in_data      upstream beat
//   out_valid/out_ready/out_ctrl/out_data  downstream beat (ctrl is 0 on bubble)
//   occupancy       number of entries held (0..2 with skid, 0..1 without)
module pipe_stage_buf #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    // m_ctrl is cleared every time M goes empty, so out_ctrl comes
    // straight from a flop and is zero on every bubble without a gate.
    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;
            logic              m_take;

            // Registered ready: depends only on the skid flop.
            assign in_ready = !s_valid;
            assign m_take   = !m_valid | out_fire;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (m_take) begin
                    if (s_valid) begin
                        // Promote the older skid beat; in_ready was low,
                        // so no new beat can arrive this cycle.
                        m_valid <= 1'b1;
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                        s_ctrl  <= '0;
                    end else if (in_fire) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        m_valid <= 1'b0;
                        m_ctrl  <= '0;
                    end
                end else if (in_fire) begin
                    // M is stalled: park the beat in S.
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                end
            end
        end else begin : g_flop
            assign s_valid  = 1'b0;
            assign in_ready = !m_valid | out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (out_fire) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks on skid and flop variants plus a
// randomised scoreboard run on a 4-bit ctrl / 64-bit data skid instance.
module tb_pipe_stage_buf;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: SKID=1, 8/32
    logic        p0_flush, p0_in_valid, p0_in_ready;
    logic [7:0]  p0_in_ctrl, p0_out_ctrl;
    logic [31:0] p0_in_data, p0_out_data;
    logic        p0_out_valid, p0_out_ready;
    logic [1:0]  p0_occ;

    // u1: SKID=0, 8/32
    logic        p1_flush, p1_in_valid, p1_in_ready;
    logic [7:0]  p1_in_ctrl, p1_out_ctrl;
    logic [31:0] p1_in_data, p1_out_data;
    logic        p1_out_valid, p1_out_ready;
    logic [1:0]  p1_occ;

    // u2: SKID=1, 4/64
    logic        p2_flush, p2_in_valid, p2_in_ready;
    logic [3:0]  p2_in_ctrl, p2_out_ctrl;
    logic [63:0] p2_in_data, p2_out_data;
    logic        p2_out_valid, p2_out_ready;
    logic [1:0]  p2_occ;

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .SKID(1)) u0 (
        .clk(clk), .reset(reset), .flush(p0_flush),
        .in_valid(p0_in_valid), .in_ready(p0_in_ready),
        .in_ctrl(p0_in_ctrl), .in_data(p0_in_data),
        .out_valid(p0_out_valid), .out_ready(p0_out_ready),
        .out_ctrl(p0_out_ctrl), .out_data(p0_out_data),
        .occupancy(p0_occ)
    );

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .SKID(0)) u1 (
        .clk(clk), .reset(reset), .flush(p1_flush),
        .in_valid(p1_in_valid), .in_ready(p1_in_ready),
        .in_ctrl(p1_in_ctrl), .in_data(p1_in_data),
        .out_valid(p1_out_valid), .out_ready(p1_out_ready),
        .out_ctrl(p1_out_ctrl), .out_data(p1_out_data),
        .occupancy(p1_occ)
    );

    pipe_stage_buf #(.CTRL_W(4), .DATA_W(64), .SKID(1)) u2 (
        .clk(clk), .reset(reset), .flush(p2_flush),
        .in_valid(p2_in_valid), .in_ready(p2_in_ready),
        .in_ctrl(p2_in_ctrl), .in_data(p2_in_data),
        .out_valid(p2_out_valid), .out_ready(p2_out_ready),
        .out_ctrl(p2_out_ctrl), .out_data(p2_out_data),
        .occupancy(p2_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [67:0] q[$];
    logic [67:0] beat;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        p0_flush = 0; p0_in_valid = 0; p0_in_ctrl = 0;
        p0_in_data = 0; p0_out_ready = 0;
        p1_flush = 0; p1_in_valid = 0; p1_in_ctrl = 0;
        p1_in_data = 0; p1_out_ready = 0;
        p2_flush = 0; p2_in_valid = 0; p2_in_ctrl = 0;
        p2_in_data = 0; p2_out_ready = 0;

        // Reset state
        step();
        step();
        chk("rst_valid", p0_out_valid, 0);
        chk("rst_ctrl", p0_out_ctrl, 0);
        chk("rst_data", p0_out_data, 0);
        chk("rst_occ", p0_occ, 0);
        chk("rst_inrdy", p0_in_ready, 1);
        chk("rst_inrdy1", p1_in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // Stream A, B, C with out_ready high
        p0_out_ready = 1;
        p0_in_valid = 1; p0_in_ctrl = 8'h81; p0_in_data = 32'h11;
        step();
        chk("strA_valid", p0_out_valid, 1);
        chk("strA_data", p0_out_data, 32'h11);
        chk("strA_ctrl", p0_out_ctrl, 8'h81);
        chk("strA_occ", p0_occ, 1);
        p0_in_ctrl = 8'h82; p0_in_data = 32'h22;
        step();
        chk("strB_valid", p0_out_valid, 1);
        chk("strB_data", p0_out_data, 32'h22);
        chk("strB_ctrl", p0_out_ctrl, 8'h82);
        chk("strB_occ", p0_occ, 1);
        p0_in_ctrl = 8'h83; p0_in_data = 32'h33;
        step();
        chk("strC_data", p0_out_data, 32'h33);
        chk("strC_ctrl", p0_out_ctrl, 8'h83);
        p0_in_valid = 0;
        step();
        chk("strE_valid", p0_out_valid, 0);
        chk("strE_ctrl", p0_out_ctrl, 0);
        chk("strE_occ", p0_occ, 0);

        // Backpressure fills the skid entry
        p0_out_ready = 0;
        p0_in_valid = 1; p0_in_ctrl = 8'h01; p0_in_data = 32'hA0;
        step();
        chk("bp1_occ", p0_occ, 1);
        chk("bp1_inrdy", p0_in_ready, 1);
        p0_in_ctrl = 8'h02; p0_in_data = 32'hB0;
        step();
        chk("bp2_occ", p0_occ, 2);
        chk("bp2_inrdy", p0_in_ready, 0);
        chk("bp2_data", p0_out_data, 32'hA0);
        p0_in_valid = 0;
        step();
        chk("bp3_data", p0_out_data, 32'hA0);
        chk("bp3_ctrl", p0_out_ctrl, 8'h01);
        chk("bp3_occ", p0_occ, 2);
        p0_out_ready = 1;
        step();
        chk("dr1_data", p0_out_data, 32'hB0);
        chk("dr1_ctrl", p0_out_ctrl, 8'h02);
        chk("dr1_occ", p0_occ, 1);
        chk("dr1_inrdy", p0_in_ready, 1);
        step();
        chk("dr2_valid", p0_out_valid, 0);
        chk("dr2_occ", p0_occ, 0);

        // Flush at occupancy 2
        p0_out_ready = 0;
        p0_in_valid = 1; p0_in_ctrl = 8'h11; p0_in_data = 32'h01;
        step();
        p0_in_ctrl = 8'h12; p0_in_data = 32'h02;
        step();
        chk("fl_pre_occ", p0_occ, 2);
        p0_flush = 1;
        p0_in_ctrl = 8'hFF; p0_in_data = 32'h55;
        step();
        chk("fl_valid", p0_out_valid, 0);
        chk("fl_ctrl", p0_out_ctrl, 0);
        chk("fl_occ", p0_occ, 0);
        chk("fl_inrdy", p0_in_ready, 1);
        p0_flush = 0; p0_in_valid = 0;
        step();
        chk("fl_post_valid", p0_out_valid, 0);
        chk("fl_post_occ", p0_occ, 0);

        // Flush discards an accepted beat
        p0_in_valid = 1; p0_in_ctrl = 8'h13; p0_in_data = 32'h03;
        step();
        chk("fl2_pre_occ", p0_occ, 1);
        p0_flush = 1;
        p0_in_ctrl = 8'h7F; p0_in_data = 32'h66;
        chk("fl2_inrdy", p0_in_ready, 1);
        step();
        chk("fl2_valid", p0_out_valid, 0);
        chk("fl2_occ", p0_occ, 0);
        p0_flush = 0; p0_in_valid = 0;
        step();
        chk("fl2_post_valid", p0_out_valid, 0);
        chk("fl2_post_ctrl", p0_out_ctrl, 0);

        // Asynchronous reset mid-cycle while holding ctrl 0xFF
        p0_in_valid = 1; p0_in_ctrl = 8'hFF; p0_in_data = 32'hDEADBEEF;
        step();
        chk("ar_pre_valid", p0_out_valid, 1);
        chk("ar_pre_ctrl", p0_out_ctrl, 8'hFF);
        p0_in_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", p0_out_valid, 0);
        chk("ar_ctrl", p0_out_ctrl, 0);
        chk("ar_data", p0_out_data, 0);
        chk("ar_occ", p0_occ, 0);
        chk("ar_inrdy", p0_in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // Flop variant: replace-on-fire with combinational ready
        p1_out_ready = 0;
        p1_in_valid = 1; p1_in_ctrl = 8'h21; p1_in_data = 32'h10;
        step();
        chk("nf_occ", p1_occ, 1);
        chk("nf_data", p1_out_data, 32'h10);
        chk("nf_inrdy0", p1_in_ready, 0);
        p1_out_ready = 1;
        p1_in_ctrl = 8'h22; p1_in_data = 32'h20;
        #1;
        chk("nf_inrdy1", p1_in_ready, 1);
        step();
        chk("nf_rep_valid", p1_out_valid, 1);
        chk("nf_rep_data", p1_out_data, 32'h20);
        chk("nf_rep_ctrl", p1_out_ctrl, 8'h22);
        chk("nf_rep_occ", p1_occ, 1);
        p1_in_valid = 0;
        step();
        chk("nf_e_valid", p1_out_valid, 0);
        chk("nf_e_ctrl", p1_out_ctrl, 0);
        chk("nf_e_occ", p1_occ, 0);

        // Random traffic against a scoreboard queue
        for (int i = 0; i < 10000; i++) begin
            step();
            if (!p2_out_valid)
                chk("rnd_bubble", p2_out_ctrl, 0);
            chk("rnd_occ", p2_occ, q.size());
            p2_in_valid  = ($urandom_range(0, 3) != 0);
            p2_out_ready = ($urandom_range(0, 1) != 0);
            p2_in_ctrl   = 4'($urandom);
            p2_in_data   = {$urandom, $urandom};
            #1;
            if (p2_out_valid && p2_out_ready) begin
                chk("rnd_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    beat = q.pop_front();
                    chk("rnd_ctrl", p2_out_ctrl, beat[67:64]);
                    chk("rnd_data", p2_out_data, beat[63:0]);
                end
            end
            if (p2_in_valid && p2_in_ready)
                q.push_back({p2_in_ctrl, p2_in_data});
        end

        // Drain remaining beats with a bounded wait
        p2_in_valid  = 0;
        p2_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (p2_out_valid) begin
                chk("drn_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    beat = q.pop_front();
                    chk("drn_ctrl", p2_out_ctrl, beat[67:64]);
                    chk("drn_data", p2_out_data, beat[63:0]);
                end
            end
        end
        chk("drn_left", q.size(), 0);
        chk("drn_valid", p2_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
